// File: rtl/read_burst_responder_if.sv
// Bundles the read-request channel, the beat return channel and the single-word memory port
// of the read burst responder.
interface read_burst_responder_if;
    logic [5:0]   rd_id_in;
    logic [31:0]  rd_addr_in;
    logic [7:0]   rd_len_in;
    logic         rd_info_valid_in;
    logic         rd_info_rdy_out;
    logic [255:0] rd_data_out;
    logic [5:0]   rd_data_id_out;
    logic         rd_data_last_out;
    logic         rd_data_valid_out;
    logic         rd_data_rdy_in;
    logic [26:0]  mem_addr_out;
    logic         mem_rd_en_out;
    logic [255:0] mem_data_in;

    modport slave (
        input  rd_id_in, rd_addr_in, rd_len_in, rd_info_valid_in, rd_data_rdy_in, mem_data_in,
        output rd_info_rdy_out, rd_data_out, rd_data_id_out, rd_data_last_out,
        output rd_data_valid_out, mem_addr_out, mem_rd_en_out
    );

    modport master (
        output rd_id_in, rd_addr_in, rd_len_in, rd_info_valid_in, rd_data_rdy_in, mem_data_in,
        input  rd_info_rdy_out, rd_data_out, rd_data_id_out, rd_data_last_out,
        input  rd_data_valid_out, mem_addr_out, mem_rd_en_out
    );
endinterface

// File: rtl/read_burst_responder.sv
// Serves one read burst at a time: issues single-word memory reads and streams the returned
// words through a 2-entry output FIFO with ID and last-beat tagging.
module read_burst_responder #(
    parameter int ADDR_LSB = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    read_burst_responder_if.slave    bus
);
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] BURST = 1'b1;
    localparam int ENTRY_W = 1 + 6 + 256;

    logic [0:0]         state_q, state_d;
    logic [5:0]         id_q;
    logic [26:0]        base_q;
    logic [7:0]         len_q;
    logic [7:0]         issuedCnt_q;
    logic               inflight_q;
    logic               inflightLast_q;
    logic [1:0]         fifoCount_q, fifoCount_d;
    logic [ENTRY_W-1:0] head_q, head_d;
    logic [ENTRY_W-1:0] tail_q, tail_d;

    logic               accept;
    logic               pop;
    logic               push;
    logic               issue;
    logic               headLast;
    logic [2:0]         occupancy;
    logic [26:0]        wordAddr;
    logic [ENTRY_W-1:0] pushEntry;

    assign bus.rd_info_rdy_out = (state_q == IDLE) && !rst;
    assign accept    = bus.rd_info_valid_in && bus.rd_info_rdy_out;
    assign pop       = (fifoCount_q != 2'd0) && bus.rd_data_rdy_in;
    assign push      = inflight_q;
    assign headLast  = head_q[ENTRY_W-1];
    assign wordAddr  = 27'(bus.rd_addr_in >> ADDR_LSB);
    assign pushEntry = {inflightLast_q, id_q, bus.mem_data_in};

    // Reads already in flight plus words still queued must never exceed the FIFO depth.
    assign occupancy = {1'b0, fifoCount_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign issue     = (state_q == BURST) && (issuedCnt_q < len_q) && (occupancy < 3'd2);

    assign bus.mem_rd_en_out     = issue;
    assign bus.mem_addr_out      = issue ? (base_q + 27'(issuedCnt_q)) : 27'd0;
    assign bus.rd_data_valid_out = (fifoCount_q != 2'd0);
    assign {bus.rd_data_last_out, bus.rd_data_id_out, bus.rd_data_out} = head_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept && (bus.rd_len_in != 8'd0)) state_d = BURST;
            BURST:   if (pop && headLast) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Shift-style FIFO: the head register always holds the oldest word.
    always_comb begin
        head_d      = head_q;
        tail_d      = tail_q;
        fifoCount_d = fifoCount_q;
        case ({push, pop})
            2'b10: begin
                if (fifoCount_q == 2'd0) head_d = pushEntry;
                else                     tail_d = pushEntry;
                fifoCount_d = fifoCount_q + 2'd1;
            end
            2'b01: begin
                head_d      = tail_q;
                fifoCount_d = fifoCount_q - 2'd1;
            end
            2'b11: begin
                if (fifoCount_q == 2'd1) begin
                    head_d = pushEntry;
                end else begin
                    head_d = tail_q;
                    tail_d = pushEntry;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            id_q           <= '0;
            base_q         <= '0;
            len_q          <= '0;
            issuedCnt_q    <= '0;
            inflight_q     <= 1'b0;
            inflightLast_q <= 1'b0;
            fifoCount_q    <= '0;
            head_q         <= '0;
            tail_q         <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                id_q        <= bus.rd_id_in;
                base_q      <= wordAddr;
                len_q       <= bus.rd_len_in;
                issuedCnt_q <= '0;
            end else if (issue) begin
                issuedCnt_q <= issuedCnt_q + 8'd1;
            end
            inflight_q     <= issue;
            inflightLast_q <= issue && ((issuedCnt_q + 8'd1) == len_q);
            fifoCount_q    <= fifoCount_d;
            head_q         <= head_d;
            tail_q         <= tail_d;
        end
    end
endmodule

// File: doc/read_burst_responder.md
READ_BURST_RESPONDER -- requirements
Module: read_burst_responder

Interface
REQ-001 Parameter ADDR_LSB, default 5, SHALL set the number of byte-address bits ignored per 256-bit memory word.
REQ-002 clk  input  1  SHALL be the single clock; all logic is rising-edge.
REQ-003 rst  input  1  SHALL be the system reset: asynchronous, active-high.
REQ-004 rd_id_in  input  6  SHALL carry the burst ID of a read request.
REQ-005 rd_addr_in  input  32  SHALL carry the burst start byte address; bits [ADDR_LSB-1:0] are ignored.
REQ-006 rd_len_in  input  8  SHALL carry the burst length in 256-bit beats.
REQ-007 rd_info_valid_in  input  1  SHALL mark the request fields as valid.
REQ-008 rd_info_rdy_out  output  1  SHALL accept the request when high together with rd_info_valid_in.
REQ-009 rd_data_out  output  256  SHALL carry the returned data beat.
REQ-010 rd_data_id_out  output  6  SHALL carry the ID of the burst that owns the beat.
REQ-011 rd_data_last_out  output  1  SHALL mark the final beat of a burst.
REQ-012 rd_data_valid_out  output  1  SHALL mark rd_data_out, rd_data_id_out and rd_data_last_out as valid.
REQ-013 rd_data_rdy_in  input  1  SHALL signal that the requester consumes the beat.
REQ-014 mem_addr_out  output  27  SHALL carry the memory word address.
REQ-015 mem_rd_en_out  output  1  SHALL issue a single-word memory read.
REQ-016 mem_data_in  input  256  SHALL carry read data, valid exactly one cycle after mem_rd_en_out.

Function
REQ-017 The FSM SHALL have exactly two states, IDLE and BURST; only one burst SHALL be outstanding at a time.
REQ-018 rd_info_rdy_out SHALL be 1 only in IDLE while rst is low.
REQ-019 On a request handshake in IDLE, the block SHALL capture id, addr[31:ADDR_LSB] and len.
- len != 0: enter BURST.
- len == 0: stay IDLE and emit no beats; a new request SHALL be accepted the next cycle.
REQ-020 In BURST, a read SHALL issue (mem_rd_en_out=1) when issued_cnt < len AND (fifo_count + inflight - pop_this_cycle) < 2.
REQ-021 mem_addr_out SHALL equal captured_addr + issued_cnt, computed modulo 2^27; wrap-around SHALL be silent.
REQ-022 Returned mem_data_in SHALL be written into a 2-entry output FIFO at the end of the cycle following its mem_rd_en_out.
REQ-023 The FIFO SHALL never overflow, and no read data SHALL ever be dropped.
REQ-024 rd_data_valid_out SHALL equal FIFO non-empty; all outputs SHALL come from FIFO head registers (no combinational path from mem_data_in).
REQ-025 While rd_data_valid_out=1 and rd_data_rdy_in=0, rd_data_out, rd_data_id_out and rd_data_last_out SHALL hold stable.
REQ-026 rd_data_last_out SHALL be 1 only on beat number len (1-based); beats SHALL return in address order.
REQ-027 Latency and throughput:
- Request handshake at cycle T gives the first mem_rd_en_out in T+1 and the first rd_data_valid_out in T+3.
- With rd_data_rdy_in held high, the block SHALL sustain one beat per cycle.
REQ-028 A handshake on the last beat SHALL return the FSM to IDLE; rd_info_rdy_out SHALL be 1 in the next cycle.
REQ-029 A simultaneous FIFO push and pop SHALL leave fifo_count unchanged.
REQ-030 rd_info_valid_in SHALL be ignored while in BURST.

Reset
REQ-031 While rst=1, all state SHALL clear asynchronously:
- FSM = IDLE; counters and FIFO = 0.
- All outputs = 0, including rd_info_rdy_out.
REQ-032 Reset mid-burst SHALL abort the burst, flush the FIFO and discard in-flight memory data.
REQ-033 No beat SHALL be presented after reset until a new request is accepted.

Verification
REQ-034 Request id=0x15, addr=0x00000040, len=4, rdy held high -> mem_addr 2,3,4,5 on consecutive cycles, valid in T+3..T+6, last on the 4th beat, id=0x15 on every beat.
REQ-035 len=3 with rd_data_rdy_in low for 5 cycles after the first valid -> at most 2 reads outstanding, data held stable, all 3 beats delivered in order, none lost.
REQ-036 addr=0xFFFFFFE0, len=2 -> mem_addr 0x7FFFFFF then 0x0000000.
REQ-037 len=0 -> no mem_rd_en_out, no valid, rd_info_rdy_out=1 the next cycle; a following len=1 request completes normally.
REQ-038 rst pulsed after the 2nd beat of a len=8 burst -> all outputs 0 immediately, no further beats, IDLE with rd_info_rdy_out=1 after release.
REQ-039 Back-to-back len=1 requests -> request accepted the cycle after each last-beat handshake, IDs never mixed.
